// File: rtl/display_page_sched.sv
// Pump display sequencer: picks VOL/COST/ALARM page, converts the page value to
// six BCD digits with a serial double-dabble engine and drives the digit codes.
module display_page_sched #(
  parameter int DWELL_CYCLES   = 150_000_000,
  parameter int REFRESH_CYCLES = 5_000_000,
  parameter int BLINK_CYCLES   = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] vol_bin,
  input  logic [19:0] cost_bin,
  input  logic        pumping,
  input  logic        alarm_req,
  input  logic [3:0]  alarm_code,
  output logic [3:0]  bcd_HEX0,
  output logic [3:0]  bcd_HEX1,
  output logic [3:0]  bcd_HEX2,
  output logic [3:0]  bcd_HEX3,
  output logic [3:0]  bcd_HEX4,
  output logic [3:0]  bcd_HEX5,
  output logic [1:0]  page,
  output logic        busy
);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [1:0] PG_VOL = 2'd0, PG_COST = 2'd1, PG_ALARM = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rot, r_first, r_busy, r_phase;
  logic [DW-1:0]    r_dwell;
  logic [RW-1:0]    r_ref;
  logic [BW-1:0]    r_bcnt;
  logic [4:0]       r_sh_cnt;
  logic [19:0]      r_bin;
  logic [23:0]      r_bcd;
  logic [1:0]       r_snap_page, r_page;
  logic [5:0][3:0]  r_dig, r_out;

  logic             w_tick, w_start, w_latch, w_lead;
  logic [1:0]       w_sel_page, w_pg_nxt;
  logic [19:0]      w_sel_val, w_sat;
  logic [23:0]      w_bcd_adj;
  logic [5:0][3:0]  w_dig_new, w_dig_nxt;

  // Rotation state is parked at VOL/0 whenever alarm or pumping overrides it.
  always_ff @(posedge clk) begin
    if (rst || alarm_req || pumping) begin
      r_rot   <= 1'b0;
      r_dwell <= '0;
    end else if (r_dwell == DW'(DWELL_CYCLES - 1)) begin
      r_rot   <= ~r_rot;
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  assign w_sel_page = alarm_req ? PG_ALARM : (pumping ? PG_VOL : {1'b0, r_rot});
  assign w_sel_val  = (w_sel_page == PG_VOL) ? vol_bin :
                      (w_sel_page == PG_COST) ? cost_bin : 20'd0;
  assign w_sat      = (w_sel_val > 20'd999_999) ? 20'd999_999 : w_sel_val;

  assign w_tick = (r_ref == RW'(REFRESH_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst || w_tick) r_ref <= '0;
    else               r_ref <= r_ref + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE:  if (w_tick || r_first) begin
                 w_start     = 1'b1;
                 w_state_nxt = S_SHIFT;
               end
      S_SHIFT: if (r_sh_cnt == 5'd19) w_state_nxt = S_LATCH;
      S_LATCH: begin
                 w_latch     = 1'b1;
                 w_state_nxt = S_IDLE;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 6; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b1;
      r_busy      <= 1'b0;
      r_sh_cnt    <= '0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_snap_page <= PG_VOL;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_first     <= 1'b0;
        r_busy      <= 1'b1;
        r_snap_page <= w_sel_page;
        r_bin       <= w_sat;
        r_bcd       <= '0;
        r_sh_cnt    <= '0;
      end
      if (r_state == S_SHIFT) begin
        {r_bcd, r_bin} <= {w_bcd_adj[22:0], r_bin, 1'b0};
        r_sh_cnt       <= r_sh_cnt + 5'd1;
      end
      if (w_latch) r_busy <= 1'b0;
    end
  end

  // Blank every digit above the most significant nonzero one; HEX0 always shows.
  always_comb begin
    w_lead    = 1'b1;
    w_dig_new = '1;
    if (r_snap_page == PG_ALARM) begin
      w_dig_new[0] = alarm_code;
    end else begin
      for (int i = 5; i >= 1; i--) begin
        if (w_lead && r_bcd[4*i +: 4] == 4'd0) begin
          w_dig_new[i] = 4'hF;
        end else begin
          w_lead       = 1'b0;
          w_dig_new[i] = r_bcd[4*i +: 4];
        end
      end
      w_dig_new[0] = r_bcd[3:0];
    end
  end

  assign w_pg_nxt  = w_latch ? r_snap_page : r_page;
  assign w_dig_nxt = w_latch ? w_dig_new : r_dig;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig  <= '1;
      r_page <= PG_VOL;
      r_out  <= '1;
    end else begin
      r_dig  <= w_dig_nxt;
      r_page <= w_pg_nxt;
      r_out  <= (w_pg_nxt == PG_ALARM && r_phase) ? '1 : w_dig_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || r_page != PG_ALARM) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_bcnt == BW'(BLINK_CYCLES - 1)) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + 1'b1;
    end
  end

  assign bcd_HEX0 = r_out[0];
  assign bcd_HEX1 = r_out[1];
  assign bcd_HEX2 = r_out[2];
  assign bcd_HEX3 = r_out[3];
  assign bcd_HEX4 = r_out[4];
  assign bcd_HEX5 = r_out[5];
  assign page     = r_page;
  assign busy     = r_busy;
endmodule

// File: tb/tb_display_page_sched.sv
// Bench for display_page_sched: directed scenarios plus random traffic, all
// checked every cycle against an edge-indexed arithmetic model of the display.
module tb_display_page_sched;
  localparam int DWC = 100, RFC = 32, BLC = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic [19:0] vol_bin = '0, cost_bin = '0;
  logic        pumping = 1'b0, alarm_req = 1'b0;
  logic [3:0]  alarm_code = '0;
  logic [3:0]  h0, h1, h2, h3, h4, h5;
  logic [1:0]  page;
  logic        busy;

  display_page_sched #(.DWELL_CYCLES(DWC), .REFRESH_CYCLES(RFC), .BLINK_CYCLES(BLC)) dut (
    .clk(clk), .rst(rst), .vol_bin(vol_bin), .cost_bin(cost_bin), .pumping(pumping),
    .alarm_req(alarm_req), .alarm_code(alarm_code),
    .bcd_HEX0(h0), .bcd_HEX1(h1), .bcd_HEX2(h2), .bcd_HEX3(h3), .bcd_HEX4(h4), .bcd_HEX5(h5),
    .page(page), .busy(busy));

  always #5 clk = ~clk;

  wire [23:0] hex = {h5, h4, h3, h2, h1, h0};

  int tests = 0, fails = 0;

  // Model state, indexed by posedge count n.
  int n = 0, e_rst = 0, e_hold = 0, e_alarm = 0, k = -1, snap_val = 0, snap_page = 0;
  bit first = 1'b1, m_busy = 1'b0;
  logic [1:0]  m_page = 2'd0;
  logic [23:0] m_dig = '1, m_out = '1;

  function automatic logic [23:0] fmt(input int v);
    logic [23:0] r;
    bit lead;
    int p, d;
    lead = 1'b1;
    p = 100000;
    r = '1;
    for (int i = 5; i >= 1; i--) begin
      d = (v / p) % 10;
      if (!(lead && d == 0)) begin
        lead = 1'b0;
        r[4*i +: 4] = d[3:0];
      end
      p = p / 10;
    end
    d = v % 10;
    r[3:0] = d[3:0];
    return r;
  endfunction

  task automatic model_step();
    int rot, sel, pg_before;
    bit tick, blank;
    n++;
    if (rst) begin
      e_rst = n; e_hold = n; k = -1; first = 1'b1;
      m_page = 2'd0; m_dig = '1; m_out = '1; m_busy = 1'b0;
    end else begin
      rot = ((n - 1 - e_hold) / DWC) % 2;
      sel = alarm_req ? 2 : (pumping ? 0 : rot);
      if (alarm_req || pumping) e_hold = n;
      tick = ((n - e_rst) % RFC) == 0;
      pg_before = int'(m_page);
      if (k < 0) begin
        if (tick || first) begin
          snap_page = sel;
          snap_val  = (sel == 0) ? int'(vol_bin) : (sel == 1) ? int'(cost_bin) : 0;
          if (snap_val > 999999) snap_val = 999999;
          k = 0; first = 1'b0; m_busy = 1'b1;
        end
      end else begin
        k++;
        if (k == 21) begin
          m_page = 2'(snap_page);
          m_dig  = (snap_page == 2) ? {20'hFFFFF, alarm_code} : fmt(snap_val);
          m_busy = 1'b0;
          k = -1;
        end
      end
      if (m_page == 2'd2 && pg_before != 2) e_alarm = n;
      blank = (m_page == 2'd2) && (pg_before == 2) && ((((n - 1 - e_alarm) / BLC) % 2) == 1);
      m_out = blank ? 24'hFFFFFF : m_dig;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: model advances at the edge, DUT compared mid-cycle.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model", {5'd0, busy, page, hex}, {5'd0, m_busy, m_page, m_out});
  endtask

  task automatic wait_busy(input logic target, input int bound);
    for (int i = 0; i < bound && busy !== target; i++) cyc();
    chk("wait_busy", {31'd0, busy}, {31'd0, target});
  endtask

  // Completes one conversion whose snapshot is taken after this call.
  task automatic conv();
    wait_busy(1'b0, 40);
    wait_busy(1'b1, 80);
    wait_busy(1'b0, 40);
  endtask

  initial begin
    int len, bad;
    logic [23:0] e;
    // 1. reset and first conversion
    pumping = 1'b1; vol_bin = 20'd123456;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_state", {5'd0, busy, page, hex}, {5'd0, 1'b0, 2'd0, 24'hFFFFFF});
    end
    rst = 1'b0;
    cyc();
    chk("first_conv_start", {31'd0, busy}, 32'd1);
    len = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      cyc();
      if (busy) len++;
    end
    chk("busy_len", len, 21);
    chk("first_digits", {6'd0, page, hex}, {6'd0, 2'd0, 24'h123456});

    // 2. boundary values
    vol_bin = 20'd0;       conv(); chk("zero", {8'd0, hex}, {8'd0, 24'hFFFFF0});
    vol_bin = 20'd1000000; conv(); chk("sat",  {8'd0, hex}, {8'd0, 24'h999999});
    vol_bin = 20'd4070;    conv(); chk("lz",   {8'd0, hex}, {8'd0, 24'hFF4070});

    // 3. rotation, then pumping locks VOL
    vol_bin = 20'd11; cost_bin = 20'd22; pumping = 1'b0;
    conv();
    bad = 0; len = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (page == 2'd1) len++;
      if (hex !== (page == 2'd1 ? 24'hFFFF22 : 24'hFFFF11)) bad++;
    end
    chk("rot_digits", bad, 0);
    chk("rot_saw_cost", {31'd0, len > 0}, 32'd1);
    for (int i = 0; i < 300 && page != 2'd1; i++) cyc();
    chk("rot_cost_shown", {30'd0, page}, 32'd1);
    pumping = 1'b1;
    conv();
    chk("pump_lock", {6'd0, page, hex}, {6'd0, 2'd0, 24'hFFFF11});
    bad = 0;
    for (int i = 0; i < 250; i++) begin
      cyc();
      if (page != 2'd0) bad++;
    end
    chk("pump_no_rot", bad, 0);

    // 4. alarm override and blink
    alarm_code = 4'd7; alarm_req = 1'b1;
    conv();
    chk("alarm_page", {6'd0, page, hex}, {6'd0, 2'd2, 24'hFFFFF7});
    for (int j = 1; j <= 24; j++) begin
      cyc();
      e = (((j - 1) / BLC) % 2) ? 24'hFFFFFF : 24'hFFFFF7;
      chk("blink", {8'd0, hex}, {8'd0, e});
    end
    alarm_req = 1'b0;
    conv();
    chk("alarm_exit", {6'd0, page, hex}, {6'd0, 2'd0, 24'hFFFF11});
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (hex !== 24'hFFFF11) bad++;
    end
    chk("alarm_exit_steady", bad, 0);

    // 5. input change mid-conversion
    vol_bin = 20'd555;
    wait_busy(1'b0, 40);
    wait_busy(1'b1, 80);
    for (int i = 0; i < 4; i++) cyc();
    vol_bin = 20'd999;
    len = 5;
    for (int i = 0; i < 40 && busy; i++) begin
      cyc();
      if (busy) len++;
    end
    chk("mid_busy_len", len, 21);
    chk("mid_digits", {8'd0, hex}, {8'd0, 24'hFFF555});
    cyc();
    chk("no_restart", {31'd0, busy}, 32'd0);

    // 6. reset mid-conversion
    wait_busy(1'b1, 80);
    for (int i = 0; i < 9; i++) cyc();
    rst = 1'b1;
    cyc();
    chk("mid_rst", {7'd0, busy, hex}, {7'd0, 1'b0, 24'hFFFFFF});
    rst = 1'b0;
    cyc();
    chk("rst_restart", {31'd0, busy}, 32'd1);
    wait_busy(1'b0, 40);
    chk("rst_digits", {8'd0, hex}, {8'd0, 24'hFFF999});

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0)
        vol_bin = ($urandom_range(0, 3) == 0) ? 20'(999990 + $urandom_range(0, 20)) : 20'($urandom);
      if ($urandom_range(0, 19) == 0) cost_bin = 20'($urandom_range(0, 1048575));
      if ($urandom_range(0, 149) == 0) pumping = ~pumping;
      if ($urandom_range(0, 199) == 0) alarm_req = ~alarm_req;
      if ($urandom_range(0, 9) == 0) alarm_code = 4'($urandom_range(0, 9));
      rst = ($urandom_range(0, 799) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
